// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcodes, FSM encoding and default widths.
// The multiply opcode is only functional when the MUL_EN macro is defined.
package exec_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 3;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_SBB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] MUL_RUN = 1'b1;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Shift-add multiplier: one partial product per cycle for DATA_W cycles.
// done is high during the final iteration; product then already includes that iteration.
module mul_seq
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic                busy;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] mcand;
   logic [DATA_W-1:0]   mplier;

   assign product = mplier[0] ? (acc + mcand) : acc;
   assign done    = busy && (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

   // iteration datapath
   always_ff @(posedge clk) begin
      if (start) begin
         acc    <= '0;
         mcand  <= {{DATA_W{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU with registered result/flags and write-enables.
// Optional multi-cycle multiply (opcode B) is built only when MUL_EN is defined.
module exec_unit
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk_pi,
   input  logic              reset_pi,
   input  logic              start_pi,
   input  logic [3:0]        opcode_pi,
   input  logic [REG_AW-1:0] dest_reg_pi,
   input  logic [DATA_W-1:0] reg1_data_pi,
   input  logic [DATA_W-1:0] reg2_data_pi,
   input  logic              current_carry_pi,
   input  logic              current_borrow_pi,
   output logic              ready_po,
   output logic              result_valid_po,
   output logic [DATA_W-1:0] result_po,
   output logic [REG_AW-1:0] dest_reg_po,
   output logic              reg_write_po,
   output logic              flag_write_po,
   output logic              new_carry_po,
   output logic              new_borrow_po
);

   logic [DATA_W:0]   ext_w;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_borrow;
   logic              alu_rw;
   logic              alu_fw;

   // Undefined flags pass through; CMP shares SUB's datapath but suppresses the register write.
   always_comb begin
      ext_w      = '0;
      alu_res    = '0;
      alu_carry  = current_carry_pi;
      alu_borrow = current_borrow_pi;
      alu_rw     = 1'b1;
      alu_fw     = 1'b1;
      case (opcode_pi)
         OP_ADD, OP_ADC: begin
            ext_w     = {1'b0, reg1_data_pi} + {1'b0, reg2_data_pi}
                        + {{DATA_W{1'b0}}, (opcode_pi == OP_ADC) & current_carry_pi};
            alu_res   = ext_w[DATA_W-1:0];
            alu_carry = ext_w[DATA_W];
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            ext_w      = {1'b0, reg1_data_pi} - {1'b0, reg2_data_pi}
                         - {{DATA_W{1'b0}}, (opcode_pi == OP_SBB) & current_borrow_pi};
            alu_res    = ext_w[DATA_W-1:0];
            alu_borrow = ext_w[DATA_W];
            alu_rw     = (opcode_pi != OP_CMP);
         end
         OP_AND: begin alu_res = reg1_data_pi & reg2_data_pi; alu_fw = 1'b0; end
         OP_OR:  begin alu_res = reg1_data_pi | reg2_data_pi; alu_fw = 1'b0; end
         OP_XOR: begin alu_res = reg1_data_pi ^ reg2_data_pi; alu_fw = 1'b0; end
         OP_NOT: begin alu_res = ~reg1_data_pi;               alu_fw = 1'b0; end
         OP_SHL: begin
            alu_res   = {reg1_data_pi[DATA_W-2:0], 1'b0};
            alu_carry = reg1_data_pi[DATA_W-1];
         end
         OP_SHR: begin
            alu_res   = {1'b0, reg1_data_pi[DATA_W-1:1]};
            alu_carry = reg1_data_pi[0];
         end
         default: begin
            alu_rw = 1'b0;
            alu_fw = 1'b0;
         end
      endcase
   end

`ifdef MUL_EN
   logic [0:0]          state;
   logic                mul_start;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_product;
   logic [REG_AW-1:0]   mul_dest;
   logic                mul_borrow;

   assign ready_po  = (state == IDLE);
   assign mul_start = start_pi && ready_po && (opcode_pi == OP_MUL);

   mul_seq #(.DATA_W(DATA_W)) u_mul_seq (
      .clk     (clk_pi),
      .rst     (reset_pi),
      .start   (mul_start),
      .a       (reg1_data_pi),
      .b       (reg2_data_pi),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk_pi) begin
      if (mul_start) begin
         mul_dest   <= dest_reg_pi;
         mul_borrow <= current_borrow_pi;
      end
   end
`else
   assign ready_po = 1'b1;
`endif

   // output register stage
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
`ifdef MUL_EN
         state <= IDLE;
`endif
         result_valid_po <= 1'b0;
         reg_write_po    <= 1'b0;
         flag_write_po   <= 1'b0;
         result_po       <= '0;
         dest_reg_po     <= '0;
         new_carry_po    <= 1'b0;
         new_borrow_po   <= 1'b0;
      end else begin
         result_valid_po <= 1'b0;
         reg_write_po    <= 1'b0;
         flag_write_po   <= 1'b0;
`ifdef MUL_EN
         if (state == MUL_RUN) begin
            if (mul_done) begin
               state           <= IDLE;
               result_valid_po <= 1'b1;
               reg_write_po    <= 1'b1;
               flag_write_po   <= 1'b1;
               result_po       <= mul_product[DATA_W-1:0];
               new_carry_po    <= |mul_product[2*DATA_W-1:DATA_W];
               new_borrow_po   <= mul_borrow;
               dest_reg_po     <= mul_dest;
            end
         end else if (mul_start) begin
            state <= MUL_RUN;
         end else
`endif
         if (start_pi) begin
            result_valid_po <= 1'b1;
            reg_write_po    <= alu_rw;
            flag_write_po   <= alu_fw;
            result_po       <= alu_res;
            dest_reg_po     <= dest_reg_pi;
            new_carry_po    <= alu_carry;
            new_borrow_po   <= alu_borrow;
         end
      end
   end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Execute stage directly downstream of the 8x16-bit register file. It consumes the two source-register operands and the current carry/borrow flags. It produces a registered result, a destination index, and new flag values, with write-enables for the writeback path. Single-cycle ALU ops run at one per cycle; an optional multiply is a multi-cycle shift-add sequence with a valid/ready handshake.

Parameters:
DATA_W, 16, operand/result width; must match the register width.
REG_AW, 3, register index width (8 registers).

Ports:
clk_pi  in  1  clock; all state updates on rising edge.
reset_pi  in  1  synchronous, active-high reset.
start_pi  in  1  operation request; sampled only when ready_po=1.
opcode_pi  in  4  operation select.
dest_reg_pi  in  REG_AW  destination register index.
reg1_data_pi  in  DATA_W  operand A (from reg1_data_po).
reg2_data_pi  in  DATA_W  operand B (from reg2_data_po).
current_carry_pi  in  1  carry flag in.
current_borrow_pi  in  1  borrow flag in.
ready_po  out  1  unit can accept start_pi this cycle.
result_valid_po  out  1  one-cycle completion pulse.
result_po  out  DATA_W  registered result.
dest_reg_po  out  REG_AW  destination index of the completed op.
reg_write_po  out  1  write result_po to dest_reg_po; qualified by result_valid_po.
flag_write_po  out  1  write the new flags; qualified by result_valid_po.
new_carry_po  out  1  full carry value to store.
new_borrow_po  out  1  full borrow value to store.

Behaviour:
- Reset: state=IDLE; ready_po=1; result_valid_po, reg_write_po and flag_write_po=0; result_po=0; dest_reg_po=0; new_carry_po and new_borrow_po=0.
- Reset asserted mid-multiply aborts the operation: no valid pulse, all outputs take their reset values.
- Opcodes:
  - 0 ADD: A+B.
  - 1 ADC: A+B+carry.
  - 2 SUB: A-B.
  - 3 SBB: A-B-borrow.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~A.
  - 8 SHL: A<<1.
  - 9 SHR: A>>1, logical.
  - A CMP: A-B, flags only.
  - B MUL: low DATA_W bits of A*B.
  - C-F: illegal.
- Arithmetic is unsigned, computed at DATA_W+1 bits.
- Flag rules:
  - ADD/ADC: carry = bit DATA_W of the sum.
  - SUB/SBB/CMP: borrow = 1 iff A < B(+borrow_in).
  - SHL: carry = A[DATA_W-1]. SHR: carry = A[0].
  - MUL: carry = 1 iff upper product half != 0.
  - A flag the op does not define is passed through from its captured input value.
- flag_write_po=1 for ADD, ADC, SUB, SBB, SHL, SHR, CMP, MUL.
- reg_write_po=1 for all legal ops except CMP.
- Illegal opcode: result_valid_po pulses with result_po=0, reg_write_po=0, flag_write_po=0.
- Handshake: accept = start_pi & ready_po. start_pi while ready_po=0 is ignored; nothing is queued.
- Operands, flags, opcode and dest are captured at accept; later input changes have no effect.
- Single-cycle ops: accepted in cycle T, outputs plus the result_valid_po pulse in T+1. ready_po stays 1, so back-to-back accepts give a throughput of 1 per cycle.
- FSM:
  - IDLE: accept MUL -> MUL_RUN; any other op completes from IDLE.
  - MUL_RUN: DATA_W iterations; ready_po=0 in cycles T+1..T+DATA_W. Last iteration -> IDLE, with result_valid_po=1 and ready_po=1 in T+DATA_W+1.
  - A new start in the completion cycle is accepted.
- result_po, dest_reg_po and the flag outputs hold their last values between pulses. The write-enables are 0 whenever result_valid_po=0.

Optional Feature:
MUL_EN.
- Defined: opcode B runs the multi-cycle multiply as described above.
- Undefined: no multiplier logic is built, the unit never leaves IDLE, ready_po is constant 1, and opcode B is handled as illegal.

Decomposition:
- Package exec_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding (IDLE, MUL_RUN), DATA_W/REG_AW defaults.
- One sub-module, mul_seq: shift-add multiplier with start/done, a DATA_W-cycle iteration count and a 2*DATA_W product. It is instantiated only under MUL_EN.

Test Plan:
- Reset: after reset_pi held for 2 cycles -> ready_po=1, result_valid_po=0, result_po=0, all write-enables 0.
- ADD then SUB back-to-back:
  - ADD A=0xFFFF, B=0x0001 -> next cycle result 0x0000, carry=1, reg_write=1, flag_write=1.
  - SUB A=0x0003, B=0x0005 (accepted the following cycle) -> result 0xFFFE, borrow=1.
- SBB and CMP:
  - SBB A=0x0010, B=0x0008, borrow_in=1 -> 0x0007, borrow=0.
  - CMP A=5, B=5 -> reg_write=0, flag_write=1, borrow=0.
- MUL (MUL_EN): A=0x0100, B=0x0100 -> ready_po low 16 cycles; pulse at T+17 with result 0x0000 and carry=1. start_pi during the busy window is ignored.
- Reset mid-MUL: assert reset_pi at T+5 -> no result_valid_po pulse ever occurs for that op, and ready_po=1 after reset.
- Illegal/logic ops:
  - opcode 0xE -> pulse with reg_write=0, flag_write=0, result 0.
  - XOR 0xF0F0^0xFFFF -> 0x0F0F, flag_write=0.
